keypad_entry_encoder: RTL



---
 rtl/keypad_entry_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/keypad_entry_encoder.sv
// Keypad front end: synchronizes and debounces ten raw digit keys,
// encodes the accepted key to BCD and shifts it into a three-digit
// entry register (min, sec_tens, sec_ones) for the timer load path.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// S_IDLE         | no key seen, debounce counter cleared
// S_DEBOUNCE     | one key held, counting stable synchronized samples
// S_ACCEPT       | single cycle after the accepting edge
// S_WAIT_RELEASE | press consumed or multi-key, waiting for all-zero
module keypad_entry_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] keys_i,
  input  logic       enable_i,
  input  logic       clear_entry_i,
  output logic [3:0] sec_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] min_o,
  output logic [1:0] digit_count_o,
  output logic       digit_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_ACCEPT,
    S_WAIT_RELEASE
  } state_t;

  localparam logic [3:0] N_C = 4'(DEBOUNCE_CYCLES);

  state_t     state_q;
  logic [9:0] sk1_q, sk2_q;
  logic [9:0] held_q;
  logic [3:0] cnt_q;

  logic [3:0] sec_ones_q, sec_tens_q, min_q;
  logic [3:0] sec_ones_d, sec_tens_d, min_d;
  logic [1:0] digit_count_q, digit_count_d;
  logic       digit_valid_q, digit_valid_d;

  logic       any_w;
  logic       onehot_w;
  logic       accept_w;
  logic [3:0] code_w;

  // Classify the synchronized key vector and detect the accepting edge
  always_comb begin
    any_w    = |sk2_q;
    onehot_w = any_w && ((sk2_q & (sk2_q - 10'd1)) == 10'd0);
    accept_w = (state_q == S_DEBOUNCE) && (sk2_q == held_q) && (cnt_q == N_C);
  end

  // Encode the held one-hot key to its BCD digit
  always_comb begin
    code_w = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (held_q[i]) code_w = 4'(i);
    end
  end

  // Two-flop synchronizer plus debounce FSM
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sk1_q   <= '0;
      sk2_q   <= '0;
      held_q  <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
    end else begin
      sk1_q <= keys_i;
      sk2_q <= sk1_q;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (onehot_w) begin
            held_q  <= sk2_q;
            cnt_q   <= 4'd1;
            state_q <= S_DEBOUNCE;
          end else if (any_w) begin
            state_q <= S_WAIT_RELEASE;
          end
        end
        S_DEBOUNCE: begin
          if (sk2_q == held_q) begin
            if (cnt_q < N_C) cnt_q <= cnt_q + 4'd1;
            else             state_q <= S_ACCEPT;
          end else if (!any_w) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (onehot_w) begin
            held_q <= sk2_q;
            cnt_q  <= 4'd1;
          end else begin
            state_q <= S_WAIT_RELEASE;
          end
        end
        S_ACCEPT: begin
          state_q <= S_WAIT_RELEASE;
        end
        S_WAIT_RELEASE: begin
          cnt_q <= '0;
          if (!any_w) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Entry register next state; clear wins over a coinciding shift
  always_comb begin
    sec_ones_d    = sec_ones_q;
    sec_tens_d    = sec_tens_q;
    min_d         = min_q;
    digit_count_d = digit_count_q;
    digit_valid_d = 1'b0;
    if (clear_entry_i) begin
      sec_ones_d    = 4'd0;
      sec_tens_d    = 4'd0;
      min_d         = 4'd0;
      digit_count_d = 2'd0;
    end else if (accept_w && enable_i) begin
      min_d         = sec_tens_q;
      sec_tens_d    = sec_ones_q;
      sec_ones_d    = code_w;
      digit_count_d = (digit_count_q == 2'd3) ? 2'd3 : digit_count_q + 2'd1;
      digit_valid_d = 1'b1;
    end
  end

  // Entry register and digit_valid pulse
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sec_ones_q    <= '0;
      sec_tens_q    <= '0;
      min_q         <= '0;
      digit_count_q <= '0;
      digit_valid_q <= 1'b0;
    end else begin
      sec_ones_q    <= sec_ones_d;
      sec_tens_q    <= sec_tens_d;
      min_q         <= min_d;
      digit_count_q <= digit_count_d;
      digit_valid_q <= digit_valid_d;
    end
  end

  assign sec_ones_o    = sec_ones_q;
  assign sec_tens_o    = sec_tens_q;
  assign min_o         = min_q;
  assign digit_count_o = digit_count_q;
  assign digit_valid_o = digit_valid_q;

endmodule
